// File: rtl/decode_stage_if.sv
// Fetch/execute-facing bundle of the decode stage. The master is the fetch and
// execute side; the slave is the decode stage itself.
interface decode_stage_if;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
  logic        f_ready;
  logic        e_stall;
  logic        e_clear;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_npc;
  logic [31:0] d_inst;
  logic [31:0] d_imm;
  logic [4:0]  d_waddr;
  logic [4:0]  d_raddr1;
  logic [4:0]  d_raddr2;
  logic        d_wren;
  logic        d_rden1;
  logic        d_rden2;
  logic [11:0] d_caddr;
  logic [2:0]  d_funct3;
  logic [15:0] d_ctrl;
  logic        d_exception;
  logic [3:0]  d_ecause;
  logic [31:0] d_etval;

  modport master (
    output f_valid, f_pc, f_inst, e_stall, e_clear,
    input  f_ready, d_valid, d_pc, d_npc, d_inst, d_imm, d_waddr, d_raddr1,
           d_raddr2, d_wren, d_rden1, d_rden2, d_caddr, d_funct3, d_ctrl,
           d_exception, d_ecause, d_etval
  );

  modport slave (
    input  f_valid, f_pc, f_inst, e_stall, e_clear,
    output f_ready, d_valid, d_pc, d_npc, d_inst, d_imm, d_waddr, d_raddr1,
           d_raddr2, d_wren, d_rden1, d_rden2, d_caddr, d_funct3, d_ctrl,
           d_exception, d_ecause, d_etval
  );
endinterface

// File: rtl/decode_stage.sv
// RV32IM decode stage: one pipeline register toward execute plus a one-entry
// skid buffer so a fetch response accepted during a stall is never dropped.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  waddr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wren;
    logic        rden1;
    logic        rden2;
    logic [11:0] caddr;
    logic [2:0]  funct3;
    logic [15:0] ctrl;
    logic        exception;
    logic [3:0]  ecause;
    logic [31:0] etval;
  } stage_t;

  stage_t      stage_q, stage_d, loaded;
  logic        skid_full_q, skid_full_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        f_ready_q, f_ready_d;

  logic [31:0] src_pc, src_inst, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [15:0] cls;
  logic        alu_reg, is_exc, transfer;

  // The skid entry is always older than anything fetch offers, so it decodes first.
  assign src_pc   = skid_full_q ? skid_pc_q   : bus.f_pc;
  assign src_inst = skid_full_q ? skid_inst_q : bus.f_inst;
  assign opcode   = src_inst[6:0];
  assign funct3   = src_inst[14:12];
  assign funct7   = src_inst[31:25];
  assign transfer = bus.f_valid & f_ready_q;

  always_comb begin
    cls = '0;
    case (opcode)
      7'b0110111: cls[0] = 1'b1;
      7'b0010111: cls[1] = 1'b1;
      7'b1101111: cls[2] = 1'b1;
      7'b1100111: cls[3] = (funct3 == 3'b000);
      7'b1100011: cls[4] = (funct3 != 3'b010) && (funct3 != 3'b011);
      7'b0000011: cls[5] = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      7'b0100011: cls[6] = (funct3 <= 3'b010);
      7'b0010011: cls[7] = 1'b1;
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          cls[14] = ~funct3[2];
          cls[15] = funct3[2];
        end else begin
          cls[7] = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end
      end
      7'b0001111: cls[9] = 1'b1;
      7'b1110011: begin
        if (funct3 == 3'b000) begin
          cls[10] = (src_inst == 32'h0000_0073);
          cls[11] = (src_inst == 32'h0010_0073);
          cls[12] = (src_inst == 32'h3020_0073);
          cls[13] = (src_inst == 32'h1050_0073);
        end else begin
          cls[8] = (funct3 != 3'b100);
        end
      end
      default: cls = '0;
    endcase
  end

  assign alu_reg = cls[7] & (opcode == 7'b0110011);
  assign is_exc  = (src_pc[1:0] != 2'b00) | (cls == 16'h0000);

  always_comb begin
    if (cls[3] | cls[5] | (cls[7] & ~alu_reg))
      imm = {{20{src_inst[31]}}, src_inst[31:20]};
    else if (cls[6])
      imm = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
    else if (cls[4])
      imm = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
    else if (cls[0] | cls[1])
      imm = {src_inst[31:12], 12'h000};
    else if (cls[2])
      imm = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};
    else if (cls[8])
      imm = {27'h0, src_inst[19:15]};
    else
      imm = 32'h0;
  end

  // Masks select the classes that write rd (C1AF), read rs1 (C0F8), read rs2 (C050).
  always_comb begin
    loaded.valid     = 1'b1;
    loaded.pc        = src_pc;
    loaded.npc       = src_pc + 32'd4;
    loaded.inst      = src_inst;
    loaded.imm       = imm;
    loaded.waddr     = src_inst[11:7];
    loaded.raddr1    = src_inst[19:15];
    loaded.raddr2    = src_inst[24:20];
    loaded.wren      = ~is_exc & (src_inst[11:7] != 5'd0) & (|(cls & 16'hC1AF));
    loaded.rden1     = (|(cls & 16'hC0F8)) | (cls[8] & ~funct3[2]);
    loaded.rden2     = (|(cls & 16'hC050)) | alu_reg;
    loaded.caddr     = src_inst[31:20];
    loaded.funct3    = funct3;
    loaded.ctrl      = is_exc ? 16'h0000 : cls;
    loaded.exception = is_exc;
    loaded.ecause    = !is_exc ? 4'd0 : ((src_pc[1:0] != 2'b00) ? 4'd0 : 4'd2);
    loaded.etval     = !is_exc ? 32'h0 : ((src_pc[1:0] != 2'b00) ? src_pc : src_inst);
  end

  always_comb begin
    stage_d     = stage_q;
    skid_full_d = skid_full_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (bus.e_clear) begin
      stage_d.valid     = 1'b0;
      stage_d.ctrl      = '0;
      stage_d.wren      = 1'b0;
      stage_d.exception = 1'b0;
      skid_full_d       = 1'b0;
    end else if (bus.e_stall) begin
      if (transfer) begin
        skid_full_d = 1'b1;
        skid_pc_d   = bus.f_pc;
        skid_inst_d = bus.f_inst;
      end
    end else if (skid_full_q | transfer) begin
      stage_d     = loaded;
      skid_full_d = 1'b0;
    end else begin
      stage_d.valid     = 1'b0;
      stage_d.ctrl      = '0;
      stage_d.wren      = 1'b0;
      stage_d.exception = 1'b0;
    end
    f_ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      stage_q.pc  <= RESET_PC;
      stage_q.npc <= RESET_PC + 32'd4;
      skid_full_q <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      f_ready_q   <= 1'b1;
    end else begin
      stage_q     <= stage_d;
      skid_full_q <= skid_full_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      f_ready_q   <= f_ready_d;
    end
  end

  assign bus.f_ready     = f_ready_q;
  assign bus.d_valid     = stage_q.valid;
  assign bus.d_pc        = stage_q.pc;
  assign bus.d_npc       = stage_q.npc;
  assign bus.d_inst      = stage_q.inst;
  assign bus.d_imm       = stage_q.imm;
  assign bus.d_waddr     = stage_q.waddr;
  assign bus.d_raddr1    = stage_q.raddr1;
  assign bus.d_raddr2    = stage_q.raddr2;
  assign bus.d_wren      = stage_q.wren;
  assign bus.d_rden1     = stage_q.rden1;
  assign bus.d_rden2     = stage_q.rden2;
  assign bus.d_caddr     = stage_q.caddr;
  assign bus.d_funct3    = stage_q.funct3;
  assign bus.d_ctrl      = stage_q.ctrl;
  assign bus.d_exception = stage_q.exception;
  assign bus.d_ecause    = stage_q.ecause;
  assign bus.d_etval     = stage_q.etval;

endmodule
